// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS-lite datapath (R-format, lw, sw, beq).
// State advances on clk; outputs decode the current state, with mem_ready gating only the FETCH load.
module multicycle_control #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           pcwritecond,
    output logic           iord,
    output logic           memread,
    output logic           memwrite,
    output logic           irwrite,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsource,
    output logic           illegal,
    output logic [3:0]     state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_R   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW  = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW  = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(6'b000100);

    state_t r_state;
    state_t w_nextState;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Unreachable codes 9-15 fall into the default arm and recover to FETCH.
    always_comb begin
        w_nextState = FETCH;
        case (r_state)
            FETCH:   w_nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_R:         w_nextState = EXEC;
                    OP_LW, OP_SW: w_nextState = MEMADR;
                    OP_BEQ:       w_nextState = BRANCH;
                    default:      w_nextState = FETCH;
                endcase
            end
            MEMADR:  w_nextState = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_nextState = mem_ready ? MEMWB : MEMRD;
            MEMWR:   w_nextState = mem_ready ? FETCH : MEMWR;
            EXEC:    w_nextState = RWB;
            MEMWB,
            RWB,
            BRANCH:  w_nextState = FETCH;
            default: w_nextState = FETCH;
        endcase
    end

    // Reset forces every output low in the same cycle, so a stalled write is withdrawn at once.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;
        state_o     = 4'd0;
        if (!reset) begin
            state_o = r_state;
            case (r_state)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    illegal = (op != OP_R) && (op != OP_LW) &&
                              (op != OP_SW) && (op != OP_BEQ);
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                RWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BRANCH: begin
                    alusrca     = 1'b1;
                    aluop       = 2'b01;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                default: state_o = r_state;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// and compares state_o plus a packed control word against hand-written expected vectors.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state_o;

    int errorCount = 0;
    int checkCount = 0;

    multicycle_control #(.OPW(6)) dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .mem_ready(mem_ready),
        .pcwrite(pcwrite),
        .pcwritecond(pcwritecond),
        .iord(iord),
        .memread(memread),
        .memwrite(memwrite),
        .irwrite(irwrite),
        .memtoreg(memtoreg),
        .regdst(regdst),
        .regwrite(regwrite),
        .alusrca(alusrca),
        .alusrcb(alusrcb),
        .aluop(aluop),
        .pcsource(pcsource),
        .illegal(illegal),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst
    //              regwrite alusrca alusrcb[1:0] aluop[1:0] pcsource[1:0] illegal
    localparam logic [16:0] W_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_FETCH_WT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] W_DECODE_IL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] W_MEMADR    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] W_MEMRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_MEMWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] W_MEMWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_EXEC      = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] W_RWB       = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] W_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ILL = 6'b000010;

    function automatic logic [16:0] ctrlWord();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal};
    endfunction

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then sample the Moore outputs.
    task automatic applyStimulus(input string tag, input logic rst, input logic [5:0] opcode,
                                 input logic rdy, input logic [3:0] expState,
                                 input logic [16:0] expWord);
        @(negedge clk);
        reset     = rst;
        op        = opcode;
        mem_ready = rdy;
        #1;
        checkOutput({tag, ".state"}, {28'd0, state_o}, {28'd0, expState});
        checkOutput({tag, ".ctrl"}, {15'd0, ctrlWord()}, {15'd0, expWord});
    endtask

    initial begin
        reset     = 1'b1;
        op        = OP_R;
        mem_ready = 1'b1;

        applyStimulus("rst0", 1'b1, OP_R, 1'b1, 4'd0, W_ZERO);
        applyStimulus("rst1", 1'b1, OP_R, 1'b1, 4'd0, W_ZERO);

        applyStimulus("r.fetch",  1'b0, OP_R, 1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("r.decode", 1'b0, OP_R, 1'b1, 4'd1, W_DECODE);
        applyStimulus("r.exec",   1'b0, OP_R, 1'b1, 4'd6, W_EXEC);
        applyStimulus("r.rwb",    1'b0, OP_R, 1'b1, 4'd7, W_RWB);

        applyStimulus("lw.fetch",  1'b0, OP_LW, 1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("lw.decode", 1'b0, OP_LW, 1'b1, 4'd1, W_DECODE);
        applyStimulus("lw.memadr", 1'b0, OP_LW, 1'b1, 4'd2, W_MEMADR);
        applyStimulus("lw.rdwait0", 1'b0, OP_SW, 1'b0, 4'd3, W_MEMRD);
        applyStimulus("lw.rdwait1", 1'b0, OP_BEQ, 1'b0, 4'd3, W_MEMRD);
        applyStimulus("lw.rddone", 1'b0, OP_ILL, 1'b1, 4'd3, W_MEMRD);
        applyStimulus("lw.memwb",  1'b0, OP_LW, 1'b1, 4'd4, W_MEMWB);

        applyStimulus("sw.fwait0", 1'b0, OP_SW, 1'b0, 4'd0, W_FETCH_WT);
        applyStimulus("sw.fwait1", 1'b0, OP_SW, 1'b0, 4'd0, W_FETCH_WT);
        applyStimulus("sw.fwait2", 1'b0, OP_SW, 1'b0, 4'd0, W_FETCH_WT);
        applyStimulus("sw.fetch",  1'b0, OP_SW, 1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("sw.decode", 1'b0, OP_SW, 1'b1, 4'd1, W_DECODE);
        applyStimulus("sw.memadr", 1'b0, OP_SW, 1'b1, 4'd2, W_MEMADR);
        applyStimulus("sw.memwr",  1'b0, OP_SW, 1'b1, 4'd5, W_MEMWR);

        applyStimulus("beq.fetch",  1'b0, OP_BEQ, 1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("beq.decode", 1'b0, OP_BEQ, 1'b1, 4'd1, W_DECODE);
        applyStimulus("beq.branch", 1'b0, OP_BEQ, 1'b1, 4'd8, W_BRANCH);

        applyStimulus("ill.fetch",  1'b0, OP_ILL, 1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("ill.decode", 1'b0, OP_ILL, 1'b1, 4'd1, W_DECODE_IL);

        applyStimulus("rsw.fetch",  1'b0, OP_SW, 1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("rsw.decode", 1'b0, OP_SW, 1'b1, 4'd1, W_DECODE);
        applyStimulus("rsw.memadr", 1'b0, OP_SW, 1'b1, 4'd2, W_MEMADR);
        applyStimulus("rsw.wait0",  1'b0, OP_SW, 1'b0, 4'd5, W_MEMWR);
        applyStimulus("rsw.wait1",  1'b0, OP_SW, 1'b0, 4'd5, W_MEMWR);
        applyStimulus("rsw.reset",  1'b1, OP_SW, 1'b0, 4'd0, W_ZERO);
        applyStimulus("rsw.resume", 1'b0, OP_R,  1'b1, 4'd0, W_FETCH_RDY);
        applyStimulus("rsw.decode", 1'b0, OP_R,  1'b1, 4'd1, W_DECODE);
        applyStimulus("rsw.exec",   1'b0, OP_R,  1'b1, 4'd6, W_EXEC);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
